// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: memory op encodings, FSM states
// and small decode helpers used by the top and the load aligner.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FIN  = 2'd2
    } lsu_state_e;

    localparam int unsigned WAIT_CNT_W = 16;

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Halfwords need an even address, words a multiple of four; bytes never fault.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lane);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lane[0];
            OP_LW, OP_SW:         return lane != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport master (
        output m_req, m_we, m_addr, m_be, m_wdata,
        input  m_rdata, m_ack
    );

    modport slave (
        input  m_req, m_we, m_addr, m_be, m_wdata,
        output m_rdata, m_ack
    );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_align
    import load_store_unit_pkg::*;
(
    input  mem_op_e     mem_op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    output logic [31:0] data
);
    logic [15:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        shifted = 16'(word >> {lane, 3'b000});
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        case (mem_op)
            OP_LB:   data = {{24{byte_s[7]}}, byte_s};
            OP_LH:   data = {{16{half_s[15]}}, half_s};
            OP_LBU:  data = {24'd0, byte_s};
            OP_LHU:  data = {16'd0, half_s};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request from execute, runs a single word-bus
// transaction with timeout, and returns an extended load result or an error.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        mem_op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              addr_err,
    output logic              bus_err,
    load_store_unit_if.master mem
);
    localparam logic [WAIT_CNT_W-1:0] TMO = 16'(TIMEOUT);

    lsu_state_e            state_q, state_d;
    mem_op_e               op_in;
    logic                  mis_in;
    logic                  accept;
    logic [3:0]            be_in;
    logic [31:0]           wdata_in;
    logic [31:0]           load_word;

    mem_op_e               op_p0;
    logic [1:0]            lane_p0;
    logic                  addr_err_p0;
    logic                  bus_err_p0;
    logic [WAIT_CNT_W-1:0] wait_cnt_p0;
    logic                  m_we_p0;
    logic [31:0]           m_addr_p0;
    logic [3:0]            m_be_p0;
    logic [31:0]           m_wdata_p0;

    assign op_in  = mem_op_e'(mem_op);
    assign mis_in = is_misaligned(op_in, addr[1:0]);
    assign accept = (state_q == ST_IDLE) && start;

    // Store lane steering: narrow data is replicated so memory can pick any lane.
    always_comb begin
        be_in    = 4'b1111;
        wdata_in = wdata;
        case (op_in)
            OP_SB: begin
                be_in    = 4'b0001 << addr[1:0];
                wdata_in = {4{wdata[7:0]}};
            end
            OP_SH: begin
                be_in    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .mem_op (op_p0),
        .lane   (lane_p0),
        .word   (mem.m_rdata),
        .data   (load_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = mis_in ? ST_FIN : ST_REQ;
            ST_REQ:  if (mem.m_ack || (wait_cnt_p0 == TMO)) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != ST_IDLE;
        done      = state_q == ST_FIN;
        mem.m_req = state_q == ST_REQ;
        addr_err  = (state_q == ST_FIN) && addr_err_p0;
        bus_err   = (state_q == ST_FIN) && bus_err_p0;
    end

    // Request capture at accept, then response/timeout tracking while in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p0       <= OP_LB;
            lane_p0     <= 2'b00;
            addr_err_p0 <= 1'b0;
            bus_err_p0  <= 1'b0;
            wait_cnt_p0 <= '0;
            m_we_p0     <= 1'b0;
            m_addr_p0   <= '0;
            m_be_p0     <= '0;
            m_wdata_p0  <= '0;
            rdata       <= '0;
        end else begin
            if (accept) begin
                op_p0       <= op_in;
                lane_p0     <= addr[1:0];
                addr_err_p0 <= mis_in;
                bus_err_p0  <= 1'b0;
                wait_cnt_p0 <= '0;
                if (!mis_in) begin
                    m_we_p0    <= is_store(op_in);
                    m_addr_p0  <= {addr[31:2], 2'b00};
                    m_be_p0    <= be_in;
                    m_wdata_p0 <= wdata_in;
                end
            end
            if (state_q == ST_REQ) begin
                if (mem.m_ack) begin
                    if (!is_store(op_p0)) rdata <= load_word;
                end else if (wait_cnt_p0 == TMO) begin
                    bus_err_p0 <= 1'b1;
                end else if (wait_cnt_p0 != '1) begin
                    wait_cnt_p0 <= wait_cnt_p0 + 1'b1;
                end
            end
        end
    end

    assign mem.m_we    = m_we_p0;
    assign mem.m_addr  = m_addr_p0;
    assign mem.m_be    = m_be_p0;
    assign mem.m_wdata = m_wdata_p0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized
// ops against a behavioural model, and reset-abort sequence.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata, rdata;
    logic        busy, done, addr_err, bus_err;

    load_store_unit_if mem_bus();

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mem_op   (mem_op),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .addr_err (addr_err),
        .bus_err  (bus_err),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        int          ackd;
        logic [31:0] word;
        logic [31:0] rd;
        logic        ae;
        logic        berr;
        int          done_c;
        int          req_c;
        logic [3:0]  be;
        logic [31:0] mwd;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    int          r_done_c, r_req_c;
    logic        r_stable, r_busy_ok, r_idle_ok, r_ae, r_berr, r_we;
    logic [31:0] r_rd, r_addr, r_mwd;
    logic [3:0]  r_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".busy"},     32'(busy), 0);
        chk({nm, ".done"},     32'(done), 0);
        chk({nm, ".addr_err"}, 32'(addr_err), 0);
        chk({nm, ".bus_err"},  32'(bus_err), 0);
        chk({nm, ".m_req"},    32'(mem_bus.m_req), 0);
        chk({nm, ".m_we"},     32'(mem_bus.m_we), 0);
        chk({nm, ".m_be"},     32'(mem_bus.m_be), 0);
        chk({nm, ".m_addr"},   mem_bus.m_addr, 0);
        chk({nm, ".m_wdata"},  mem_bus.m_wdata, 0);
        chk({nm, ".rdata"},    rdata, 0);
    endtask

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd3, 3'd5: return 1;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    // Behavioural expectation for one operation from the architectural rules.
    function automatic vec_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                                   input int ackd, input logic [31:0] word, input logic [31:0] prev_rd);
        vec_t v;
        int   sz, ofs, val;
        logic mis, ok;
        sz  = op_size(op);
        ofs = int'(a[1:0]);
        mis = (ofs % sz) != 0;
        ok  = !mis && (ackd <= TMO);
        v.op = op; v.a = a; v.wd = wd; v.ackd = ackd; v.word = word;
        v.ae     = mis;
        v.berr   = !mis && (ackd > TMO);
        v.done_c = mis ? 1 : (ok ? ackd + 2 : TMO + 2);
        v.req_c  = mis ? 0 : (ok ? ackd + 1 : TMO + 1);
        v.be     = (op < 3'd5) ? 4'hF : 4'(((1 << sz) - 1) << ofs);
        v.mwd    = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
                   (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        v.rd = prev_rd;
        if (ok && op < 3'd5) begin
            val = int'(word >> (8 * ofs));
            case (op)
                3'd0: begin val = val & 255;   if (val > 127)   val = val - 256;   end
                3'd1: begin val = val & 65535; if (val > 32767) val = val - 65536; end
                3'd3: val = val & 255;
                3'd4: val = val & 65535;
                default: val = int'(word);
            endcase
            v.rd = val;
        end
        return v;
    endfunction

    // Issue one op starting in an idle cycle and play memory; results land in r_*.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input int ackd, input logic [31:0] word, input logic junk);
        start  = 1'b1;
        mem_op = op;
        addr   = a;
        wdata  = wd;
        mem_bus.m_ack   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_bus.m_rdata = $urandom;
        r_done_c = -1; r_req_c = 0; r_stable = 1'b1; r_busy_ok = 1'b1; r_idle_ok = 1'b0;
        r_ae = 1'bx; r_berr = 1'bx; r_rd = 'x; r_we = 1'bx; r_addr = 'x; r_mwd = 'x; r_be = 'x;
        @(posedge clk); #1;
        start = 1'b0;
        mem_bus.m_ack = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (!busy) r_busy_ok = 1'b0;
            if (mem_bus.m_req) begin
                if (r_req_c == 0) begin
                    r_we = mem_bus.m_we; r_addr = mem_bus.m_addr;
                    r_be = mem_bus.m_be; r_mwd = mem_bus.m_wdata;
                end else if ({r_we, r_addr, r_be, r_mwd} !==
                             {mem_bus.m_we, mem_bus.m_addr, mem_bus.m_be, mem_bus.m_wdata}) begin
                    r_stable = 1'b0;
                end
                if (r_req_c == ackd) begin
                    mem_bus.m_ack   = 1'b1;
                    mem_bus.m_rdata = word;
                end
                r_req_c++;
            end
            if (done) begin
                r_done_c = c; r_ae = addr_err; r_berr = bus_err; r_rd = rdata;
                break;
            end
            if (junk) begin
                start  = 1'($urandom_range(0, 1));
                mem_op = 3'($urandom);
                addr   = $urandom;
                wdata  = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            mem_bus.m_ack = 1'b0;
        end
        if (r_done_c >= 0) begin
            @(posedge clk); #1;
            r_idle_ok = !busy && !done;
        end
    endtask

    task automatic run_chk(input string nm, input vec_t v, input logic junk);
        do_op(v.op, v.a, v.wd, v.ackd, v.word, junk);
        chk({nm, ".done_cycle"}, 32'(r_done_c), 32'(v.done_c));
        chk({nm, ".addr_err"},   32'(r_ae), 32'(v.ae));
        chk({nm, ".bus_err"},    32'(r_berr), 32'(v.berr));
        chk({nm, ".rdata"},      r_rd, v.rd);
        chk({nm, ".busy_held"},  32'(r_busy_ok), 1);
        chk({nm, ".idle_after"}, 32'(r_idle_ok), 1);
        chk({nm, ".req_cycles"}, 32'(r_req_c), 32'(v.req_c));
        if (v.req_c > 0 && r_req_c > 0) begin
            chk({nm, ".m_be"},   32'(r_be), 32'(v.be));
            chk({nm, ".m_addr"}, r_addr, v.a & 32'hFFFF_FFFC);
            chk({nm, ".m_we"},   32'(r_we), 32'(v.op >= 3'd5));
            chk({nm, ".stable"}, 32'(r_stable), 1);
            if (v.op >= 3'd5) chk({nm, ".m_wdata"}, r_mwd, v.mwd);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired before completion");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        logic [31:0] mrd;

        rst_n = 1'b0; start = 1'b0; mem_op = '0; addr = '0; wdata = '0;
        mem_bus.m_ack = 1'b0; mem_bus.m_rdata = '0;
        #3;
        chk_reset("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        //            op    addr          wdata         ackd word          rdata         ae    be_err done req be     m_wdata
        vecs.push_back(vec_t'{3'd2, 32'h100, 32'h0,        0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 2, 1, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd0, 32'h103, 32'h0,        0,  32'h80123456, 32'hFFFFFF80, 1'b0, 1'b0, 2, 1, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd3, 32'h103, 32'h0,        0,  32'h80123456, 32'h00000080, 1'b0, 1'b0, 2, 1, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd4, 32'h102, 32'h0,        0,  32'h80123456, 32'h00008012, 1'b0, 1'b0, 2, 1, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd6, 32'h202, 32'h1234ABCD, 0,  32'hFFFFFFFF, 32'h00008012, 1'b0, 1'b0, 2, 1, 4'hC, 32'hABCDABCD});
        vecs.push_back(vec_t'{3'd2, 32'h101, 32'h0,        0,  32'h0,        32'h00008012, 1'b1, 1'b0, 1, 0, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd6, 32'h203, 32'h1234ABCD, 0,  32'h0,        32'h00008012, 1'b1, 1'b0, 1, 0, 4'hC, 32'h0});
        vecs.push_back(vec_t'{3'd1, 32'h102, 32'h0,        2,  32'h87651234, 32'hFFFF8765, 1'b0, 1'b0, 4, 3, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd5, 32'h001, 32'h123456A5, 1,  32'h0,        32'hFFFF8765, 1'b0, 1'b0, 3, 2, 4'h2, 32'hA5A5A5A5});
        vecs.push_back(vec_t'{3'd5, 32'h203, 32'h000000C3, 0,  32'h0,        32'hFFFF8765, 1'b0, 1'b0, 2, 1, 4'h8, 32'hC3C3C3C3});
        vecs.push_back(vec_t'{3'd2, 32'h300, 32'h0,        99, 32'h0,        32'hFFFF8765, 1'b0, 1'b1, 6, 5, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd2, 32'h304, 32'h0,        4,  32'h11223344, 32'h11223344, 1'b0, 1'b0, 6, 5, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd7, 32'h10C, 32'hCAFEF00D, 0,  32'h0,        32'h11223344, 1'b0, 1'b0, 2, 1, 4'hF, 32'hCAFEF00D});
        vecs.push_back(vec_t'{3'd1, 32'h100, 32'h0,        0,  32'h00007FFF, 32'h00007FFF, 1'b0, 1'b0, 2, 1, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd0, 32'h102, 32'h0,        0,  32'h00FF0000, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 1, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd0, 32'h001, 32'h0,        0,  32'h00007F00, 32'h0000007F, 1'b0, 1'b0, 2, 1, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd4, 32'h000, 32'h0,        0,  32'hFFFF8000, 32'h00008000, 1'b0, 1'b0, 2, 1, 4'hF, 32'h0});
        vecs.push_back(vec_t'{3'd7, 32'h102, 32'h0,        0,  32'h0,        32'h00008000, 1'b1, 1'b0, 1, 0, 4'hF, 32'h0});

        foreach (vecs[i]) run_chk($sformatf("vec%0d", i), vecs[i], 1'b0);

        mrd = 32'h00008000;
        for (int i = 0; i < 200; i++) begin
            v = model(3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom_range(0, TMO + 2), $urandom, mrd);
            run_chk($sformatf("rnd%0d", i), v, 1'b1);
            mrd = v.rd;
        end

        // Reset in the middle of a request: bus drops at once, late ack is ignored.
        start = 1'b1; mem_op = 3'd2; addr = 32'h400; wdata = 32'h0; mem_bus.m_ack = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rstmid.m_req_before", 32'(mem_bus.m_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.m_req_async", 32'(mem_bus.m_req), 0);
        chk_reset("rstmid.during");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        mem_bus.m_ack = 1'b1; mem_bus.m_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_bus.m_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_reset($sformatf("rstmid.after%0d", i));
            @(posedge clk); #1;
        end

        v = model(3'd2, 32'h500, 32'h0, 0, 32'h0BADF00D, 32'h0);
        run_chk("recover", v, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
